// File: rtl/countdown_timer_ctrl.sv
// BCD MM:SS countdown timer driven by a one-cycle seconds tick.
// Counts to 00:00, then holds an alarm for ALARM_SECS ticks before returning to idle.
module countdown_timer_ctrl #(
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_ones,
  input  logic [2:0] preset_sec_tens,
  input  logic [3:0] preset_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  state_t             state, state_next;
  logic [3:0]         min_tens_next, min_ones_next, sec_ones_next;
  logic [2:0]         sec_tens_next;
  logic [CNT_W-1:0]   alarm_cnt, alarm_cnt_next;
  logic               running_next, alarm_next, done_next;

  logic [3:0]         ld_mt, ld_mo, ld_so;
  logic [2:0]         ld_st;
  logic [3:0]         dec_mt, dec_mo, dec_so;
  logic [2:0]         dec_st;
  logic               dec_zero;

  assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                (sec_tens == 3'd0) && (sec_ones == 4'd0);

  // Preset clamping to the largest legal BCD digit.
  always_comb begin
    ld_mt = (preset_min_tens > 4'd9) ? 4'd9 : preset_min_tens;
    ld_mo = (preset_min_ones > 4'd9) ? 4'd9 : preset_min_ones;
    ld_st = (preset_sec_tens > 3'd5) ? 3'd5 : preset_sec_tens;
    ld_so = (preset_sec_ones > 4'd9) ? 4'd9 : preset_sec_ones;
  end

  // One-second BCD decrement with borrow chain; only used when the count is nonzero.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      if (sec_tens == 3'd0) begin
        dec_st = 3'd5;
        if (min_ones == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end else begin
          dec_mo = min_ones - 4'd1;
        end
      end else begin
        dec_st = sec_tens - 3'd1;
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
               (dec_st == 3'd0) && (dec_so == 4'd0);
  end

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 3'd0;
      sec_ones  <= 4'd0;
      alarm_cnt <= '0;
    end else begin
      state     <= state_next;
      min_tens  <= min_tens_next;
      min_ones  <= min_ones_next;
      sec_tens  <= sec_tens_next;
      sec_ones  <= sec_ones_next;
      alarm_cnt <= alarm_cnt_next;
    end
  end

  // Next-state and next-datapath logic; priority stop > start > load.
  always_comb begin
    state_next     = state;
    min_tens_next  = min_tens;
    min_ones_next  = min_ones;
    sec_tens_next  = sec_tens;
    sec_ones_next  = sec_ones;
    alarm_cnt_next = alarm_cnt;
    case (state)
      S_IDLE: begin
        if (start && !zero) begin
          state_next = S_RUN;
        end else if (load) begin
          min_tens_next = ld_mt;
          min_ones_next = ld_mo;
          sec_tens_next = ld_st;
          sec_ones_next = ld_so;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_PAUSE;
        end else if (sec_tick) begin
          // A zero count can only arrive via a PAUSE reload; alarm without underflow.
          if (zero) begin
            state_next = S_ALARM;
          end else begin
            min_tens_next = dec_mt;
            min_ones_next = dec_mo;
            sec_tens_next = dec_st;
            sec_ones_next = dec_so;
            if (dec_zero) state_next = S_ALARM;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next = S_RUN;
        end else if (load) begin
          min_tens_next = ld_mt;
          min_ones_next = ld_mo;
          sec_tens_next = ld_st;
          sec_ones_next = ld_so;
        end
      end
      S_ALARM: begin
        if (stop) begin
          state_next     = S_IDLE;
          alarm_cnt_next = '0;
        end else if (sec_tick) begin
          if ((alarm_cnt + CNT_W'(1)) >= CNT_W'(ALARM_SECS)) begin
            state_next     = S_IDLE;
            alarm_cnt_next = '0;
          end else begin
            alarm_cnt_next = alarm_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    running_next = (state_next == S_RUN);
    alarm_next   = (state_next == S_ALARM);
    done_next    = (state == S_RUN) && (state_next == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running    <= 1'b0;
      alarm      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      running    <= running_next;
      alarm      <= alarm_next;
      done_pulse <= done_next;
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: expected digits/flags are queued per step
// and compared one cycle later against the registered outputs.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, sec_tick, start, stop, load;
  logic [3:0] preset_min_tens, preset_min_ones, preset_sec_ones;
  logic [2:0] preset_sec_tens;
  logic [3:0] min_tens, min_ones, sec_ones;
  logic [2:0] sec_tens;
  logic       zero, running, alarm, done_pulse;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [14:0] digits;
    logic [3:0]  flags;   // {zero, running, alarm, done_pulse}
  } exp_t;

  exp_t sb[$];

  countdown_timer_ctrl #(.ALARM_SECS(5)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .start(start), .stop(stop), .load(load),
    .preset_min_tens(preset_min_tens), .preset_min_ones(preset_min_ones),
    .preset_sec_tens(preset_sec_tens), .preset_sec_ones(preset_sec_ones),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .zero(zero), .running(running), .alarm(alarm), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] d(input int mt, input int mo, input int st, input int so);
    return {4'(mt), 4'(mo), 3'(st), 4'(so)};
  endfunction

  task automatic preset(input int mt, input int mo, input int st, input int so);
    preset_min_tens = 4'(mt);
    preset_min_ones = 4'(mo);
    preset_sec_tens = 3'(st);
    preset_sec_ones = 4'(so);
  endtask

  // One clock with the given inputs held across the rising edge; outputs settle #1 after.
  task automatic cyc(input logic r, input logic t, input logic s, input logic p, input logic l);
    @(negedge clk);
    rst = r; sec_tick = t; start = s; stop = p; load = l;
    @(posedge clk);
    #1;
    rst = 1'b0; sec_tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input logic r, input logic t, input logic s, input logic p, input logic l,
                      input string tag, input logic [14:0] ed, input logic [3:0] ef);
    exp_t e;
    exp_t got;
    logic [14:0] od;
    logic [3:0]  of;
    e.tag = tag; e.digits = ed; e.flags = ef;
    sb.push_back(e);
    cyc(r, t, s, p, l);
    got = sb.pop_front();
    od = {min_tens, min_ones, sec_tens, sec_ones};
    of = {zero, running, alarm, done_pulse};
    checks++;
    assert (od === got.digits) else begin
      failures++;
      $error("FAIL %s digits: observed %h expected %h", got.tag, od, got.digits);
    end
    checks++;
    assert (of === got.flags) else begin
      failures++;
      $error("FAIL %s flags(z,r,a,d): observed %b expected %b", got.tag, of, got.flags);
    end
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    preset(0, 0, 0, 0);

    step(1, 0, 0, 0, 0, "reset", d(0,0,0,0), 4'b1000);

    // Test 1: 00:03 countdown into alarm and alarm timeout.
    preset(0, 0, 0, 3);
    step(0, 0, 0, 0, 1, "t1_load", d(0,0,0,3), 4'b0000);
    step(0, 0, 1, 0, 0, "t1_start", d(0,0,0,3), 4'b0100);
    idle(9);
    step(0, 1, 0, 0, 0, "t1_tick1", d(0,0,0,2), 4'b0100);
    idle(9);
    step(0, 1, 0, 0, 0, "t1_tick2", d(0,0,0,1), 4'b0100);
    idle(9);
    step(0, 1, 0, 0, 0, "t1_tick3", d(0,0,0,0), 4'b1011);
    step(0, 0, 0, 0, 0, "t1_done_drop", d(0,0,0,0), 4'b1010);
    for (int i = 1; i <= 4; i++) begin
      idle(2);
      step(0, 1, 0, 0, 0, "t1_alarm_tick", d(0,0,0,0), 4'b1010);
    end
    idle(2);
    step(0, 1, 0, 0, 0, "t1_alarm_end", d(0,0,0,0), 4'b1000);

    // Test 2: full borrow chain, then 60 ticks.
    preset(1, 0, 0, 0);
    step(0, 0, 0, 0, 1, "t2_load", d(1,0,0,0), 4'b0000);
    step(0, 0, 1, 0, 0, "t2_start", d(1,0,0,0), 4'b0100);
    step(0, 1, 0, 0, 0, "t2_borrow", d(0,9,5,9), 4'b0100);
    for (int i = 0; i < 59; i++) begin
      cyc(0, 1, 0, 0, 0);
      idle(1);
    end
    step(0, 1, 0, 0, 0, "t2_60ticks", d(0,8,5,9), 4'b0100);

    // Test 3: clamped preset loaded from PAUSE.
    step(0, 0, 0, 1, 0, "t3_pause", d(0,8,5,9), 4'b0000);
    preset(15, 12, 7, 10);
    step(0, 0, 0, 0, 1, "t3_clamp", d(9,9,5,9), 4'b0000);
    step(0, 0, 1, 0, 0, "t3_start", d(9,9,5,9), 4'b0100);
    step(0, 1, 0, 0, 0, "t3_tick", d(9,9,5,8), 4'b0100);

    // Test 4: stop wins over a same-cycle tick.
    step(0, 0, 0, 1, 0, "t4_pause", d(9,9,5,8), 4'b0000);
    preset(0, 0, 0, 5);
    step(0, 0, 0, 0, 1, "t4_load", d(0,0,0,5), 4'b0000);
    step(0, 0, 1, 0, 0, "t4_start", d(0,0,0,5), 4'b0100);
    step(0, 1, 0, 1, 0, "t4_stop_tick", d(0,0,0,5), 4'b0000);
    step(0, 1, 0, 0, 0, "t4_pause_tick", d(0,0,0,5), 4'b0000);
    step(0, 0, 1, 0, 0, "t4_resume", d(0,0,0,5), 4'b0100);
    step(0, 1, 0, 0, 0, "t4_tick", d(0,0,0,4), 4'b0100);

    // Test 5: stop from PAUSE holds digits; start at zero ignored; reset mid-run.
    step(0, 0, 0, 1, 0, "t5_pause", d(0,0,0,4), 4'b0000);
    step(0, 0, 0, 1, 0, "t5_idle_hold", d(0,0,0,4), 4'b0000);
    step(1, 0, 0, 0, 0, "t5_reset", d(0,0,0,0), 4'b1000);
    step(0, 0, 1, 0, 0, "t5_start_zero", d(0,0,0,0), 4'b1000);
    preset(0, 3, 2, 1);
    step(0, 0, 0, 0, 1, "t5_load", d(0,3,2,1), 4'b0000);
    step(0, 0, 1, 0, 0, "t5_run", d(0,3,2,1), 4'b0100);
    step(1, 1, 0, 0, 0, "t5_rst_run", d(0,0,0,0), 4'b1000);

    // Test 6: cancel alarm early, then a full-length alarm.
    preset(0, 0, 0, 1);
    step(0, 0, 0, 0, 1, "t6_load", d(0,0,0,1), 4'b0000);
    step(0, 0, 1, 0, 0, "t6_start", d(0,0,0,1), 4'b0100);
    step(0, 1, 0, 0, 0, "t6_alarm", d(0,0,0,0), 4'b1011);
    step(0, 1, 0, 0, 0, "t6_atick1", d(0,0,0,0), 4'b1010);
    step(0, 1, 0, 0, 0, "t6_atick2", d(0,0,0,0), 4'b1010);
    step(0, 0, 0, 1, 0, "t6_cancel", d(0,0,0,0), 4'b1000);
    step(0, 0, 0, 0, 1, "t6_reload", d(0,0,0,1), 4'b0000);
    step(0, 0, 1, 0, 0, "t6_restart", d(0,0,0,1), 4'b0100);
    step(0, 1, 0, 0, 0, "t6_alarm2", d(0,0,0,0), 4'b1011);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      step(0, 1, 0, 0, 0, "t6_a2tick", d(0,0,0,0), 4'b1010);
    end
    idle(1);
    step(0, 1, 0, 0, 0, "t6_a2end", d(0,0,0,0), 4'b1000);
    step(0, 0, 0, 0, 0, "t6_idle", d(0,0,0,0), 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
